// File: rtl/riscv_bp_pkg.sv
// Shared types for the branch prediction unit and its EX-stage tracker.
package riscv_bp_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b11,
    STRONG_T  = 2'b10
  } bp_pred_t;

  function automatic logic bp_taken(bp_pred_t p);
    return p[1];
  endfunction

endpackage

// File: rtl/riscv_bp_perfcnt.sv
// Wrapping performance counter with synchronous clear that beats increment.
module riscv_bp_perfcnt #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            inc_i,
  input  logic            clr_i,
  output logic [XLEN-1:0] cnt_o
);

  logic [XLEN-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    r_cnt <= '0;
    else if (clr_i) r_cnt <= '0;
    else if (inc_i) r_cnt <= r_cnt + XLEN'(1);
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/riscv_bp_track.sv
// Carries the ID-stage prediction into EX, owns global history and drives
// the prediction RAM write side when a conditional branch resolves.
module riscv_bp_track
  import riscv_bp_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int HAS_BPU        = 0,
  parameter int BP_GLOBAL_BITS = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [1:0]                bp_bp_predict_i,
  input  logic                      id_valid_i,
  input  logic                      id_stall_i,
  input  logic                      id_flush_i,
  input  logic                      ex_stall_i,
  input  logic                      ex_flush_i,
  input  logic                      ex_branch_i,
  input  logic                      ex_btaken_i,
  input  logic                      cnt_clr_i,
  output logic [BP_GLOBAL_BITS-1:0] bu_bp_history_o,
  output logic [1:0]                bu_bp_predict_o,
  output logic                      bu_bp_btaken_o,
  output logic                      bu_bp_update_o,
  output logic                      ex_mispredict_o,
  output logic [XLEN-1:0]           cnt_branch_o,
  output logic [XLEN-1:0]           cnt_mispredict_o
);

  bp_pred_t                  r_pred;
  logic                      r_vld;
  logic [BP_GLOBAL_BITS-1:0] r_hist;
  logic [BP_GLOBAL_BITS-1:0] w_hist_nxt;
  logic                      w_bubble;
  logic                      w_resolve;
  logic                      w_mispredict;
  bp_pred_t                  w_pred_in;

  assign w_bubble  = id_stall_i | id_flush_i | ~id_valid_i;
  assign w_pred_in = (HAS_BPU != 0) ? bp_pred_t'(bp_bp_predict_i) : STRONG_NT;

  // Prediction is kept while bubbled so the EX port never sees garbage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld  <= 1'b0;
      r_pred <= STRONG_NT;
    end else if (ex_flush_i) begin
      r_vld  <= 1'b0;
    end else if (!ex_stall_i) begin
      if (w_bubble) begin
        r_vld  <= 1'b0;
      end else begin
        r_vld  <= 1'b1;
        r_pred <= w_pred_in;
      end
    end
  end

  assign w_resolve    = r_vld & ex_branch_i & ~ex_stall_i & ~ex_flush_i;
  assign w_mispredict = w_resolve & (bp_taken(r_pred) ^ ex_btaken_i);

  if (BP_GLOBAL_BITS == 1) begin : g_hist1
    assign w_hist_nxt = ex_btaken_i;
  end else begin : g_histn
    assign w_hist_nxt = {r_hist[BP_GLOBAL_BITS-2:0], ex_btaken_i};
  end

  // Output shows pre-update history during the resolve cycle (RAM write index).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        r_hist <= '0;
    else if (w_resolve) r_hist <= w_hist_nxt;
  end

  riscv_bp_perfcnt #(.XLEN(XLEN)) u_cnt_branch (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (w_resolve),
    .clr_i  (cnt_clr_i),
    .cnt_o  (cnt_branch_o)
  );

  riscv_bp_perfcnt #(.XLEN(XLEN)) u_cnt_mispredict (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (w_mispredict),
    .clr_i  (cnt_clr_i),
    .cnt_o  (cnt_mispredict_o)
  );

  assign bu_bp_history_o = r_hist;
  assign bu_bp_predict_o = r_pred;
  assign bu_bp_btaken_o  = ex_btaken_i;
  assign bu_bp_update_o  = w_resolve & (HAS_BPU != 0);
  assign ex_mispredict_o = w_mispredict;

endmodule
